div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Sits in the execute stage
//   beside the ALU and takes the same forwarded operands A/B. DivResult is muxed with ALUResult
//   ahead of the EX/MEM register. While a divide is in flight, DivStall freezes IF/ID/EX.
// PARAMETERS
//   WIDTH   32   operand/result width (even, >= 4)
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous, active-low reset
//   DivStart   in   1      EX holds a valid M-ext divide this cycle
//   DivOp      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A          in   WIDTH  dividend (forwarded rs1)
//   B          in   WIDTH  divisor (forwarded rs2)
//   Flush      in   1      EX flush from hazard unit; aborts any operation
//   DivResult  out  WIDTH  quotient or remainder; valid when DivDone=1, held until next start
//   DivDone    out  1      one-cycle pulse: DivResult valid, EX may advance
//   DivStall   out  1      combinational stall request to hazard unit
// BEHAVIOUR
//   Reset (reset_n=0 at clk edge): state=IDLE, DivResult=0, DivDone=0, count=0, internal regs 0.
//   States: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: DivStart=1 & Flush=0 -> latch op, signs, |A|,|B| (magnitudes for signed ops), count=0.
//       B==0 or (signed & A==MIN & B==-1): skip BUSY, go to DONE with the special result.
//       Otherwise go to BUSY.
//   - BUSY: one restoring step per cycle (shift rem:quo left 1, trial subtract, keep if >=0).
//       Exactly WIDTH steps; after step WIDTH go to DONE. DivStart is ignored in BUSY.
//   - DONE: DivDone=1 for exactly one cycle; DivResult registered this cycle; return to IDLE.
//       DivStart in DONE is not accepted; the next op starts from IDLE on the following cycle.
//   DivStall = (state==IDLE & DivStart & ~Flush) | (state==BUSY).
//       Low in DONE, so EX advances on the DivDone cycle.
//   Latency: start accepted at cycle t -> DivDone at t+WIDTH+1 (normal), t+1 (special case).
//   Sign fix-up (at the BUSY->DONE transition):
//       quotient negated if sign(A)!=sign(B) for DIV; remainder takes sign of A for REM.
//       Unsigned ops take no fix-up.
//   Special results, per RISC-V spec:
//       B==0 -> quotient all ones (DIV/DIVU), remainder = A (REM/REMU).
//       Overflow (DIV/REM, A=2^(W-1), B=-1) -> quotient = A, remainder = 0.
//   Width: remainder accumulator is WIDTH+1 bits so the trial subtract never loses carry.
//       MIN magnitude 2^(W-1) fits in WIDTH bits unsigned.
//   Flush:
//       Any state -> IDLE next edge, DivDone=0, DivResult unchanged.
//       Flush with DivStart in IDLE -> not accepted. Flush has priority over the DONE pulse.
//   Reset mid-operation: immediate return to IDLE, all outputs to reset values, no DivDone.
// STRUCTURE
//   Shared package riscv_pkg:
//     - div_op_t enum {DIV, DIVU, REM, REMU}
//     - div_state_t enum {IDLE, BUSY, DONE}
//     - localparam DIV_OP_W = 2
//   Sub-module div_step:
//     - combinational single restoring iteration, WIDTH param
//     - in: rem, quo, divisor; out: rem_next, quo_next
//   Counter is $clog2(WIDTH)+1 bits.
// TESTING
//   1) DIVU A=100,B=7 -> DivStall high 33 cycles, DivDone at t+33, DivResult=14; REMU same -> 2.
//   2) DIV A=-20,B=3 -> 0xFFFFFFFA (-6); REM A=-20,B=3 -> 0xFFFFFFFE (-2); REM A=20,B=-3 -> 2.
//   3) DIVU A=5,B=0 -> DivDone at t+1, 0xFFFFFFFF; REM A=0x80000000,B=0xFFFFFFFF -> t+1, 0.
//   4) DIV A=0x80000000,B=-1 -> DivResult=0x80000000 at t+1; DIV A=0x80000000,B=1 -> 0x80000000 at t+33.
//   5) Start DIVU 100/7, Flush at t+10 -> IDLE at t+11, no DivDone, DivStall low;
//      new DIVU 9/3 -> 3 at its own t+33.
//   6) reset_n=0 at t+5 of a divide -> next edge DivResult=0, DivDone=0, DivStall=0 (DivStart low).

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared execute-stage types for the M-extension divider
package riscv_pkg;

  localparam int DIV_OP_W = 2;

  typedef enum logic [DIV_OP_W-1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Bit 0 of the opcode marks the unsigned variants, bit 1 the remainder variants.
  function automatic logic op_is_signed(div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One spare bit above the accumulator turns the trial borrow into a plain sign bit.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_next = trial[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                DivStart,
  input  logic [DIV_OP_W-1:0] DivOp,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic                Flush,
  output logic [WIDTH-1:0]    DivResult,
  output logic                DivDone,
  output logic                DivStall
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_next;
  div_op_t          op_in;
  logic             in_signed, in_rem, a_neg, b_neg;
  logic             div_zero, ovf, special, start_ok, last_step;
  logic [WIDTH-1:0] a_mag, b_mag, special_res, q_fix, r_fix;

  logic             neg_q, neg_r, rem_sel_q;
  logic [WIDTH:0]   rem_q, rem_next;
  logic [WIDTH-1:0] quo_q, quo_next, dsr_q;
  logic [CNT_W-1:0] count;

  assign op_in     = div_op_t'(DivOp);
  assign in_signed = op_is_signed(op_in);
  assign in_rem    = op_is_rem(op_in);
  assign a_neg     = in_signed & A[WIDTH-1];
  assign b_neg     = in_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  assign div_zero  = (B == '0);
  assign ovf       = in_signed & (A == MIN_VAL) & (B == '1);
  assign special   = div_zero | ovf;
  assign start_ok  = (state == IDLE) & DivStart & ~Flush;
  assign last_step = (count == CNT_W'(WIDTH - 1));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = in_rem ? A : '1;
    else if (ovf) special_res = in_rem ? '0 : A;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fix = neg_q ? -quo_next : quo_next;
  assign r_fix = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    DivStall   = 1'b0;
    DivDone    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          DivStall   = 1'b1;
          state_next = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        DivStall = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        DivDone    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A flush aborts everything, including a result about to be reported.
    if (Flush) begin
      state_next = IDLE;
      DivDone    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      rem_sel_q <= 1'b0;
      DivResult <= '0;
    end else if (!Flush) begin
      if (start_ok) begin
        rem_q     <= '0;
        quo_q     <= a_mag;
        dsr_q     <= b_mag;
        count     <= '0;
        neg_q     <= ~in_rem & (a_neg ^ b_neg);
        neg_r     <= in_rem & a_neg;
        rem_sel_q <= in_rem;
        if (special) DivResult <= special_res;
      end else if (state == BUSY) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        count <= count + 1'b1;
        if (last_step) DivResult <= rem_sel_q ? r_fix : q_fix;
      end
    end
  end

endmodule
